ninjakun_chr_arb: RTL and testbench

// - Shares one 32-bit graphics-ROM port (SDRAM bridge) between three fetchers: FG tile, BG tile, sprite engine.
// - Round-robin arbitration, req/ack handshake to the ROM, and per-requester data register plus fetch strobe (xxFT).
// - The sprite engine's CHR fetch strobe and data (SPCFT/SPCDT) come from this block.
// - Sits between the video fetchers and the ROM loader/SDRAM controller.

---
 rtl/ninjakun_chr_arb_pkg.sv | 20 ++
 rtl/ninjakun_chr_arb_rr3.sv | 34 +++
 rtl/ninjakun_chr_arb.sv | 132 +++++++++++++
 tb/tb_ninjakun_chr_arb.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ninjakun_chr_arb_pkg.sv
// rtl/ninjakun_chr_arb_pkg.sv - shared source codes, FSM states and defaults for the CHR ROM arbiter
package ninjakun_chr_arb_pkg;

    localparam int AW_DEF  = 13;
    localparam int TMO_DEF = 64;

    typedef enum logic [1:0] {
        SRC_FG = 2'd0,
        SRC_BG = 2'd1,
        SRC_SP = 2'd2
    } src_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

endpackage

// File: rtl/ninjakun_chr_arb_rr3.sv
// rtl/ninjakun_chr_arb_rr3.sv - combinational 3-way round-robin picker
module chr_rr3
    import ninjakun_chr_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       valid
);

    // Search starts just after the last-granted source; an unused code 3 behaves like SP.
    always_comb begin
        grant = SRC_FG;
        valid = |req;
        case (last)
            SRC_FG: begin
                if (req[SRC_BG])      grant = SRC_BG;
                else if (req[SRC_SP]) grant = SRC_SP;
                else                  grant = SRC_FG;
            end
            SRC_BG: begin
                if (req[SRC_SP])      grant = SRC_SP;
                else if (req[SRC_FG]) grant = SRC_FG;
                else                  grant = SRC_BG;
            end
            default: begin
                if (req[SRC_FG])      grant = SRC_FG;
                else if (req[SRC_BG]) grant = SRC_BG;
                else                  grant = SRC_SP;
            end
        endcase
    end

endmodule

// File: rtl/ninjakun_chr_arb.sv
// rtl/ninjakun_chr_arb.sv - shares one 32-bit graphics ROM port between FG, BG and sprite fetchers
module ninjakun_chr_arb
    import ninjakun_chr_arb_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int TMO = TMO_DEF
)(
    input  logic          VCLKx4,
    input  logic          RESET,

    input  logic          FGREQ,
    input  logic [AW-1:0] FGAD,
    output logic [31:0]   FGDT,
    output logic          FGFT,

    input  logic          BGREQ,
    input  logic [AW-1:0] BGAD,
    output logic [31:0]   BGDT,
    output logic          BGFT,

    input  logic          SPREQ,
    input  logic [AW-1:0] SPCAD,
    output logic [31:0]   SPCDT,
    output logic          SPCFT,

    output logic [AW+1:0] ROMAD,
    output logic          ROMRQ,
    input  logic          ROMACK,
    input  logic [31:0]   ROMDT,
    output logic          ROMERR
);

    localparam int CW = $clog2(TMO + 1);

    state_t        state;
    src_t          gnt;
    logic [1:0]    last;
    logic [CW-1:0] cnt;

    logic [1:0]    pick;
    logic          pick_valid;
    logic [AW-1:0] pick_addr;
    logic          timeout;
    logic [31:0]   wdata;

    chr_rr3 u_rr3 (
        .req   ({SPREQ, BGREQ, FGREQ}),
        .last  (last),
        .grant (pick),
        .valid (pick_valid)
    );

    always_comb begin
        pick_addr = FGAD;
        case (pick)
            SRC_BG:  pick_addr = BGAD;
            SRC_SP:  pick_addr = SPCAD;
            default: pick_addr = FGAD;
        endcase
    end

    assign timeout = (cnt == CW'(TMO - 1));
    // An abandoned fetch delivers zero so the fetcher never sees stale data.
    assign wdata   = ROMACK ? ROMDT : 32'd0;

    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            state  <= ST_IDLE;
            gnt    <= SRC_FG;
            last   <= SRC_SP;
            cnt    <= '0;
            FGDT   <= '0;
            BGDT   <= '0;
            SPCDT  <= '0;
            FGFT   <= 1'b0;
            BGFT   <= 1'b0;
            SPCFT  <= 1'b0;
            ROMAD  <= '0;
            ROMRQ  <= 1'b0;
            ROMERR <= 1'b0;
        end else begin
            FGFT  <= 1'b0;
            BGFT  <= 1'b0;
            SPCFT <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt   <= src_t'(pick);
                        ROMAD <= {pick, pick_addr};
                        ROMRQ <= 1'b1;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ROMACK || timeout) begin
                        ROMRQ <= 1'b0;
                        if (!ROMACK)
                            ROMERR <= 1'b1;
                        // Strobe is registered here so it is high during DELIVER.
                        case (gnt)
                            SRC_BG: begin
                                BGDT <= wdata;
                                BGFT <= 1'b1;
                            end
                            SRC_SP: begin
                                SPCDT <= wdata;
                                SPCFT <= 1'b1;
                            end
                            default: begin
                                FGDT <= wdata;
                                FGFT <= 1'b1;
                            end
                        endcase
                        state <= ST_DELIVER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DELIVER: begin
                    last  <= gnt;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ninjakun_chr_arb.sv
// tb/tb_ninjakun_chr_arb.sv - directed self-checking bench for the CHR ROM arbiter
module tb_ninjakun_chr_arb;

    localparam int AW = 13;

    logic          VCLKx4;
    logic          RESET;
    logic          FGREQ, BGREQ, SPREQ;
    logic [AW-1:0] FGAD, BGAD, SPCAD;
    logic [31:0]   FGDT, BGDT, SPCDT;
    logic          FGFT, BGFT, SPCFT;
    logic [AW+1:0] ROMAD;
    logic          ROMRQ;
    logic          ROMACK;
    logic [31:0]   ROMDT;
    logic          ROMERR;

    int   checks = 0;
    int   errors = 0;
    logic auto_ack = 1'b0;
    logic rq_prev  = 1'b0;
    logic [31:0] exp_dt [3];
    logic [31:0] dval;
    logic [AW-1:0] exp_addr [3];

    ninjakun_chr_arb #(.AW(AW), .TMO(64)) dut (
        .VCLKx4 (VCLKx4),
        .RESET  (RESET),
        .FGREQ  (FGREQ),
        .FGAD   (FGAD),
        .FGDT   (FGDT),
        .FGFT   (FGFT),
        .BGREQ  (BGREQ),
        .BGAD   (BGAD),
        .BGDT   (BGDT),
        .BGFT   (BGFT),
        .SPREQ  (SPREQ),
        .SPCAD  (SPCAD),
        .SPCDT  (SPCDT),
        .SPCFT  (SPCFT),
        .ROMAD  (ROMAD),
        .ROMRQ  (ROMRQ),
        .ROMACK (ROMACK),
        .ROMDT  (ROMDT),
        .ROMERR (ROMERR)
    );

    initial VCLKx4 = 1'b0;
    always #5 VCLKx4 = ~VCLKx4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge; in auto mode ACK the second cycle ROMRQ is seen high.
    task automatic cyc();
        @(negedge VCLKx4);
        if (auto_ack)
            ROMACK = ROMRQ && rq_prev;
        rq_prev = ROMRQ;
    endtask

    initial begin
        RESET = 1'b1;
        FGREQ = 1'b0; BGREQ = 1'b0; SPREQ = 1'b0;
        FGAD = '0; BGAD = '0; SPCAD = '0;
        ROMACK = 1'b0; ROMDT = '0;
        repeat (3) cyc();

        check("rst_romrq", {31'd0, ROMRQ}, 32'd0);
        check("rst_romad", {17'd0, ROMAD}, 32'd0);
        check("rst_ft",    {29'd0, SPCFT, BGFT, FGFT}, 32'd0);
        check("rst_dt_or", FGDT | BGDT | SPCDT, 32'd0);
        check("rst_err",   {31'd0, ROMERR}, 32'd0);

        // Sprite engine alone, address changes after its first strobe.
        RESET = 1'b0;
        SPREQ = 1'b1;
        SPCAD = 13'h0100;
        ROMDT = 32'hA5A5_0001;
        auto_ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cyc();
            check("sp_rq_issue", {31'd0, ROMRQ}, 32'd1);
            check("sp_romad", {17'd0, ROMAD},
                  (k == 0) ? {17'd0, 2'd2, 13'h0100} : {17'd0, 2'd2, 13'h0108});
            cyc();
            check("sp_rq_wait", {31'd0, ROMRQ}, 32'd1);
            check("sp_ft_early", {31'd0, SPCFT}, 32'd0);
            cyc();
            check("sp_ft", {31'd0, SPCFT}, 32'd1);
            check("sp_dt", SPCDT, 32'hA5A5_0001);
            check("sp_rq_deliver", {31'd0, ROMRQ}, 32'd0);
            cyc();
            check("sp_ft_off", {31'd0, SPCFT}, 32'd0);
            SPCAD = 13'h0108;
        end

        // All three requesting: FG, BG, SP twice round, one strobe at a time.
        FGAD = 13'h0AAA;
        BGAD = 13'h1555;
        FGREQ = 1'b1;
        BGREQ = 1'b1;
        exp_dt[0] = 32'd0;
        exp_dt[1] = 32'd0;
        exp_dt[2] = 32'hA5A5_0001;
        exp_addr[0] = 13'h0AAA;
        exp_addr[1] = 13'h1555;
        exp_addr[2] = 13'h0108;
        for (int i = 0; i < 6; i++) begin
            dval  = 32'h1000_0000 + i;
            ROMDT = dval;
            cyc();
            check("rr_src", {30'd0, ROMAD[AW+1:AW]}, i % 3);
            check("rr_addr", {19'd0, ROMAD[AW-1:0]}, {19'd0, exp_addr[i % 3]});
            cyc();
            cyc();
            exp_dt[i % 3] = dval;
            check("rr_ft", {29'd0, SPCFT, BGFT, FGFT}, 32'd1 << (i % 3));
            check("rr_fgdt", FGDT, exp_dt[0]);
            check("rr_bgdt", BGDT, exp_dt[1]);
            check("rr_spdt", SPCDT, exp_dt[2]);
            cyc();
            check("rr_ft_off", {29'd0, SPCFT, BGFT, FGFT}, 32'd0);
        end

        // FG fetch with no ACK ever: timeout after 64 WAIT cycles.
        BGREQ = 1'b0;
        SPREQ = 1'b0;
        auto_ack = 1'b0;
        ROMACK = 1'b0;
        cyc();
        check("to_rq_issue", {31'd0, ROMRQ}, 32'd1);
        check("to_src", {30'd0, ROMAD[AW+1:AW]}, 32'd0);
        repeat (64) cyc();
        check("to_rq_last_wait", {31'd0, ROMRQ}, 32'd1);
        check("to_ft_early", {31'd0, FGFT}, 32'd0);
        cyc();
        check("to_rq_drop", {31'd0, ROMRQ}, 32'd0);
        check("to_ft", {31'd0, FGFT}, 32'd1);
        check("to_dt", FGDT, 32'd0);
        check("to_err", {31'd0, ROMERR}, 32'd1);
        FGREQ = 1'b0;
        cyc();
        // Late ACK while idle must be ignored.
        ROMACK = 1'b1;
        ROMDT  = 32'hDEAD_BEEF;
        cyc();
        ROMACK = 1'b0;
        check("late_ft", {29'd0, SPCFT, BGFT, FGFT}, 32'd0);
        check("late_fgdt", FGDT, 32'd0);
        check("late_rq", {31'd0, ROMRQ}, 32'd0);
        check("late_err", {31'd0, ROMERR}, 32'd1);

        // Reset while BG is waiting.
        BGREQ = 1'b1;
        cyc();
        check("rb_src", {30'd0, ROMAD[AW+1:AW]}, 32'd1);
        check("rb_addr", {19'd0, ROMAD[AW-1:0]}, 32'h1555);
        cyc();
        check("rb_rq_wait", {31'd0, ROMRQ}, 32'd1);
        RESET = 1'b1;
        cyc();
        check("rb_rq", {31'd0, ROMRQ}, 32'd0);
        check("rb_bgft", {31'd0, BGFT}, 32'd0);
        check("rb_fgdt", FGDT, 32'd0);
        check("rb_bgdt", BGDT, 32'd0);
        check("rb_spdt", SPCDT, 32'd0);
        check("rb_err", {31'd0, ROMERR}, 32'd0);
        RESET = 1'b0;
        FGREQ = 1'b1;
        cyc();
        check("rb_first_fg", {30'd0, ROMAD[AW+1:AW]}, 32'd0);
        check("rb_no_bgft", {31'd0, BGFT}, 32'd0);
        auto_ack = 1'b1;
        ROMDT = 32'h0000_00F6;
        cyc();
        cyc();
        check("rb_fgft", {31'd0, FGFT}, 32'd1);
        check("rb_fgdt_new", FGDT, 32'h0000_00F6);
        FGREQ = 1'b0;
        ROMDT = 32'h1234_5678;

        // BG drops its request during WAIT; the fetch still lands.
        cyc();
        check("bd_ft_off", {29'd0, SPCFT, BGFT, FGFT}, 32'd0);
        cyc();
        check("bd_src", {30'd0, ROMAD[AW+1:AW]}, 32'd1);
        cyc();
        BGREQ = 1'b0;
        cyc();
        check("bd_bgft", {31'd0, BGFT}, 32'd1);
        check("bd_bgdt", BGDT, 32'h1234_5678);
        check("bd_fgdt_kept", FGDT, 32'h0000_00F6);
        cyc();
        check("bd_bgft_once", {31'd0, BGFT}, 32'd0);
        cyc();
        check("bd_idle_rq", {31'd0, ROMRQ}, 32'd0);
        check("bd_idle_ft", {29'd0, SPCFT, BGFT, FGFT}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
